// File: rtl/square_wave_synth.sv
// square_wave_synth: programmable 50%-duty square wave source; define SQUARE_WAVE_SYNTH_CYCLE_COUNT_EN to add the edge_count output
module square_wave_synth #(
    parameter int CLK_FREQ = 100_000_000,
    parameter int W        = 26
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [W-1:0] freq_in,
    input  logic         load,
    output logic         busy,
    output logic         waveform,
    output logic [W-1:0] half_period,
`ifdef SQUARE_WAVE_SYNTH_CYCLE_COUNT_EN
    output logic [W-1:0] edge_count,
`endif
    output logic         err
);
    localparam int N  = CLK_FREQ / 2;
    localparam int NW = $clog2(N + 1);
    localparam int IW = $clog2(NW);
    localparam logic [W-1:0] DVD0 = W'(N) << (W - NW);

    typedef enum logic [1:0] {IDLE, DIV, RUN} state_t;

    state_t        r_state, w_next;
    logic [W-1:0]  r_div, r_dvd, r_rem, r_q, r_cnt, w_q;
    logic [IW-1:0] r_iter;
    logic          r_zero;
    logic [W:0]    w_sh, w_diff;
    logic          w_ge, w_accept, w_done, w_tick;

    assign busy     = r_state == DIV;
    assign w_accept = load && !busy;
    assign w_done   = busy && (r_zero || r_iter == IW'(NW - 1));
    assign w_sh     = {r_rem, r_dvd[W-1]};
    assign w_diff   = w_sh - {1'b0, r_div};
    assign w_ge     = w_sh >= {1'b0, r_div};
    assign w_q      = W'({r_q, w_ge});
    assign w_tick   = r_cnt == half_period - W'(1);

    // state register
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            r_state <= IDLE;
        else
            r_state <= w_next;
    end

    // next state: a load always starts a (possibly trivial) division; zero frequency lands back in IDLE
    always_comb begin
        w_next = r_state;
        if (w_accept)
            w_next = DIV;
        else if (w_done)
            w_next = r_zero ? IDLE : RUN;
    end

    // restoring divider, result commit and toggle generator; the old waveform keeps running while dividing
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_div       <= '0;
            r_dvd       <= '0;
            r_rem       <= '0;
            r_q         <= '0;
            r_iter      <= '0;
            r_zero      <= 1'b0;
            r_cnt       <= '0;
            waveform    <= 1'b0;
            half_period <= '0;
            err         <= 1'b0;
`ifdef SQUARE_WAVE_SYNTH_CYCLE_COUNT_EN
            edge_count  <= '0;
`endif
        end else begin
            if (w_accept) begin
                r_div  <= freq_in;
                r_zero <= freq_in == '0;
                r_dvd  <= DVD0;
                r_rem  <= '0;
                r_q    <= '0;
                r_iter <= '0;
            end else if (busy) begin
                r_rem  <= W'(w_ge ? w_diff : w_sh);
                r_q    <= w_q;
                r_dvd  <= r_dvd << 1;
                r_iter <= r_iter + IW'(1);
            end
            if (w_done) begin
                half_period <= r_zero ? '0 : (w_q == '0 ? W'(1) : w_q);
                err         <= !r_zero && w_q == '0;
                waveform    <= 1'b0;
                r_cnt       <= '0;
`ifdef SQUARE_WAVE_SYNTH_CYCLE_COUNT_EN
                edge_count  <= '0;
`endif
            end else if (half_period != '0) begin
                r_cnt    <= w_tick ? '0 : r_cnt + W'(1);
                waveform <= w_tick ? !waveform : waveform;
`ifdef SQUARE_WAVE_SYNTH_CYCLE_COUNT_EN
                if (w_tick && !waveform && edge_count != '1)
                    edge_count <= edge_count + W'(1);
`endif
            end
        end
    end
endmodule

// File: tb/tb_square_wave_synth.sv
// tb_square_wave_synth: scoreboard bench for square_wave_synth at CLK_FREQ=1000 and CLK_FREQ=100 MHz
module tb_square_wave_synth;
    localparam int W = 26;

    typedef struct packed {
        logic [W-1:0] hp;
        logic         err;
        logic [31:0]  blen;
    } exp_t;

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic         a_load = 1'b0, b_load = 1'b0;
    logic [W-1:0] a_freq = '0, b_freq = '0;
    logic         a_busy, a_wf, a_err, b_busy, b_wf, b_err;
    logic [W-1:0] a_hp, b_hp;
`ifdef SQUARE_WAVE_SYNTH_CYCLE_COUNT_EN
    logic [W-1:0] a_ec, b_ec;
`endif

    exp_t qa[$];
    exp_t qb[$];
    exp_t e;
    int   n_checks = 0;
    int   n_fail = 0;
    int   blen_a = 0;
    int   blen_b = 0;
    int   hi, tog;
    logic prv;

    always #5 clk = ~clk;

    square_wave_synth #(.CLK_FREQ(1000), .W(W)) dut_a (
        .clk(clk), .reset(reset), .freq_in(a_freq), .load(a_load), .busy(a_busy),
        .waveform(a_wf), .half_period(a_hp),
`ifdef SQUARE_WAVE_SYNTH_CYCLE_COUNT_EN
        .edge_count(a_ec),
`endif
        .err(a_err)
    );

    square_wave_synth #(.CLK_FREQ(100_000_000), .W(W)) dut_b (
        .clk(clk), .reset(reset), .freq_in(b_freq), .load(b_load), .busy(b_busy),
        .waveform(b_wf), .half_period(b_hp),
`ifdef SQUARE_WAVE_SYNTH_CYCLE_COUNT_EN
        .edge_count(b_ec),
`endif
        .err(b_err)
    );

    task automatic chk(input string name, input longint act, input longint exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    // one-cycle load pulse; the expected result is queued only for requests that will complete
    task automatic pulse(input bit sel, input logic [W-1:0] f, input bit push,
                         input logic [W-1:0] hp, input logic er, input int bl);
        exp_t x;
        x.hp = hp;
        x.err = er;
        x.blen = 32'(bl);
        if (sel) begin
            b_freq = f;
            b_load = 1'b1;
            if (push) qb.push_back(x);
        end else begin
            a_freq = f;
            a_load = 1'b1;
            if (push) qa.push_back(x);
        end
        tick();
        a_load = 1'b0;
        b_load = 1'b0;
    endtask

    task automatic wait_idle(input bit sel);
        int t;
        t = 0;
        while ((sel ? b_busy : a_busy) && t < 200) begin
            tick();
            t++;
        end
        chk("busy_cleared", sel ? b_busy : a_busy, 0);
    endtask

    // called on the first negedge after the completion edge
    task automatic measure(input bit sel, input int hp);
        int t;
        t = 0;
        while ((sel ? b_wf : a_wf) == 1'b0 && t <= 4 * hp) begin tick(); t++; end
        chk("first_rise", t, hp);
        t = 0;
        while ((sel ? b_wf : a_wf) == 1'b1 && t <= 4 * hp) begin tick(); t++; end
        chk("high_time", t, hp);
        t = 0;
        while ((sel ? b_wf : a_wf) == 1'b0 && t <= 4 * hp) begin tick(); t++; end
        chk("low_time", t, hp);
    endtask

    // monitor: measures each busy window and checks the committed result when busy falls
    always @(negedge clk) begin
        if (reset) begin
            blen_a = 0;
            blen_b = 0;
        end else begin
            if (a_busy)
                blen_a++;
            else if (blen_a != 0) begin
                chk("a_result_expected", qa.size() > 0, 1);
                if (qa.size() > 0) begin
                    e = qa.pop_front();
                    chk("a_half_period", a_hp, e.hp);
                    chk("a_err", a_err, e.err);
                    chk("a_busy_cycles", blen_a, e.blen);
                end
                blen_a = 0;
            end
            if (b_busy)
                blen_b++;
            else if (blen_b != 0) begin
                chk("b_result_expected", qb.size() > 0, 1);
                if (qb.size() > 0) begin
                    e = qb.pop_front();
                    chk("b_half_period", b_hp, e.hp);
                    chk("b_err", b_err, e.err);
                    chk("b_busy_cycles", blen_b, e.blen);
                end
                blen_b = 0;
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        tick();
        tick();
        chk("rst_busy", a_busy, 0);
        chk("rst_waveform", a_wf, 0);
        chk("rst_half_period", a_hp, 0);
        chk("rst_err", a_err, 0);
        chk("rst_b_half_period", b_hp, 0);
`ifdef SQUARE_WAVE_SYNTH_CYCLE_COUNT_EN
        chk("rst_edge_count", a_ec, 0);
`endif
        #2 reset = 1'b0;
        tick();

        pulse(0, 7, 1, 71, 0, 9);
        wait_idle(0);
        measure(0, 71);

        pulse(0, 0, 1, 0, 0, 1);
        wait_idle(0);
        hi = 0;
        repeat (1000) begin tick(); hi += int'(a_wf); end
        chk("zero_freq_low", hi, 0);

        pulse(0, 600, 1, 1, 1, 9);
        wait_idle(0);
        measure(0, 1);
        pulse(0, 250, 1, 2, 0, 9);
        wait_idle(0);
        measure(0, 2);

        pulse(0, 5, 1, 100, 0, 9);
        tog = 0;
        prv = a_wf;
        for (int t = 0; t < 40 && a_busy; t++) begin
            a_freq = 9;
            a_load = (t == 2);
            tick();
            if (a_wf != prv) tog++;
            prv = a_wf;
        end
        a_load = 1'b0;
        chk("div_old_toggles", tog >= 3, 1);
        chk("completion_low", a_wf, 0);
        wait_idle(0);
        measure(0, 100);

        pulse(0, 7, 0, 0, 0, 0);
        tick();
        tick();
        tick();
        #2 reset = 1'b1;
        #1;
        chk("arst_busy", a_busy, 0);
        chk("arst_waveform", a_wf, 0);
        chk("arst_half_period", a_hp, 0);
        chk("arst_err", a_err, 0);
        @(negedge clk);
        #2 reset = 1'b0;
        hi = 0;
        repeat (300) begin tick(); hi += int'(a_wf); end
        chk("post_reset_low", hi, 0);
        chk("post_reset_half_period", a_hp, 0);

        pulse(0, 10, 1, 50, 0, 9);
        wait_idle(0);
`ifdef SQUARE_WAVE_SYNTH_CYCLE_COUNT_EN
        repeat (1000) tick();
        chk("edge_count_1000", a_ec, 10);
`else
        measure(0, 50);
`endif

        for (int i = 0; i < 3; i++) begin
            e.hp = 2;
            e.err = 1'b0;
            e.blen = 9;
            qa.push_back(e);
        end
        a_freq = 250;
        a_load = 1'b1;
        repeat (25) tick();
        a_load = 1'b0;
        wait_idle(0);

        pulse(1, 1_000_000, 1, 50, 0, 26);
        wait_idle(1);
        measure(1, 50);

        tick();
        chk("a_queue_drained", qa.size(), 0);
        chk("b_queue_drained", qb.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
